multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Moore-style main controller for the multicycle RV32I datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects and write enables, and produces the 2-bit ALUOp consumed directly by the downstream ALU decoder.
- Also generates ImmSrc for the immediate extender and handshakes with a memory that may stall.

Parameters:
- USE_MEM_READY, 1: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  opcode from instruction register; stable from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = Result.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register / OldPC enable.
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = register A.
- alu_src_b  out  2  00 = register B, 01 = ImmExt, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = sub (beq), 10 = decode by funct3/funct7.
- reg_write  out  1  register file write enable.
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- instr_retire  out  1  high on the final cycle of each legal instruction.

Behaviour:
- State register updates on the rising edge of clk; async rst forces state = FETCH.
- While rst is high: pc_write, ir_write, reg_write, mem_write, illegal_op and instr_retire = 0. Mux selects take their FETCH values.
- Internal signals: pc_update and branch. pc_write = pc_update | (branch & zero), combinational in zero.
- All outputs not listed for a state are 0.
- imm_src is combinational from op, independent of state:
  - 0000011 / 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else 00
- FETCH:
  - adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - ir_write = pc_update = mem_ready.
  - mem_ready = 1 -> DECODE; else stay in FETCH.
- DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target computed into ALUOut). Next state by op:
  - lw / sw -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other opcode -> FETCH with illegal_op = 1; no register, memory or PC write occurs.
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. op = 0000011 -> MEMREAD; else -> MEMWRITE.
- MEMREAD: adr_src = 1, result_src = 00. Stay until mem_ready, then -> MEMWB.
- MEMWB: result_src = 01, reg_write = 1, instr_retire = 1. Next -> FETCH.
- MEMWRITE: adr_src = 1, result_src = 00, mem_write = 1, held every cycle while waiting. mem_ready -> FETCH with instr_retire = 1 in that cycle.
- EXECUTER: alu_src_a = 10, alu_src_b = 00, alu_op = 10. Next -> ALUWB.
- EXECUTEI: alu_src_a = 10, alu_src_b = 01, alu_op = 10. Next -> ALUWB.
- JAL: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_update = 1. Next -> ALUWB.
- ALUWB: result_src = 00, reg_write = 1, instr_retire = 1. Next -> FETCH.
- BEQ: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, branch = 1, instr_retire = 1. Next -> FETCH.
- Latency in cycles, mem_ready always 1:
  - lw 5
  - sw 4
  - R-type / I-type 4
  - jal 4
  - beq 3
  - illegal 2
- Every stall cycle adds one cycle.
- rst asserted mid-instruction: any pending write is abandoned immediately; after release, execution restarts in FETCH.
- Unreachable state encodings -> FETCH on the next edge.
- State encoding is free; the state is not a port.

Test Plan:
- Reset then add x3,x1,x2 (op 0110011), mem_ready = 1:
  - states FETCH, DECODE, EXECUTER, ALUWB.
  - alu_op = 10 in EXECUTER.
  - reg_write and instr_retire = 1 only in cycle 4.
  - pc_write = 1 only in cycle 1.
- lw (0000011) with mem_ready low for 2 cycles in MEMREAD:
  - 7 cycles total, adr_src = 1 throughout MEMREAD.
  - reg_write = 1 with result_src = 01 exactly once.
- sw (0100011) with mem_ready = 0 for 3 MEMWRITE cycles:
  - mem_write = 1 for 4 consecutive cycles, imm_src = 01.
  - reg_write never asserted.
- beq (1100011), zero = 1 then zero = 0 on a second beq:
  - pc_write = 1 in BEQ for the first, 0 for the second.
  - alu_op = 01, imm_src = 10.
- jal (1101111): pc_write = 1 in FETCH and JAL; reg_write = 1 in ALUWB; imm_src = 11.
- op = 1111111, then assert rst in MEMWRITE of a following sw:
  - illegal_op pulses once in DECODE, and the next state is FETCH.
  - All enables drop to 0 asynchronously on rst; after release the controller is in FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multicycle RV32I datapath.
// Every instruction is sequenced through fetch, decode, execute, memory and
// writeback states. The controller drives the datapath mux selects, the write
// enables, the 2-bit ALUOp and the ImmSrc code for the immediate extender.
//
// Memory handshake: the controller holds the request (address select, and
// mem_write for stores) stable for as long as it waits. A cycle in which
// mem_ready is high completes the access. On that edge the controller
// advances, so each access completes exactly once. When USE_MEM_READY is 0,
// every access completes in its first cycle.
module multicycle_control_fsm #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic       illegal_op,
  output logic       instr_retire
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_JAL      = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  logic [3:0] state_q, state_d;
  logic       mem_rdy;

  // Raw per-state enables; rst gates them below.
  logic pc_update, branch;
  logic ir_write_raw, mem_write_raw, reg_write_raw;
  logic illegal_raw, retire_raw;

  assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

  // State register; async reset returns the controller to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic. Unused encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls. Anything a state does not set stays 0.
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    retire_raw    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = mem_rdy;
        pc_update    = mem_rdy;
      end
      S_DECODE: begin
        // The branch target is computed into ALUOut here.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegal_raw = 1'b0;
          default:                                  illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_MEMWRITE: begin
        // The write request is held while memory stalls.
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        retire_raw    = mem_rdy;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        retire_raw = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
  end

  // The immediate format depends only on the opcode, not on the state.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // While rst is high, the enables are forced low without waiting for a clock.
  assign pc_write     = ~rst & (pc_update | (branch & zero));
  assign ir_write     = ~rst & ir_write_raw;
  assign mem_write    = ~rst & mem_write_raw;
  assign reg_write    = ~rst & reg_write_raw;
  assign illegal_op   = ~rst & illegal_raw;
  assign instr_retire = ~rst & retire_raw;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm.
// The driver walks an instruction through its phases and pushes the expected
// output word for every cycle. The monitor pops and compares one word per
// cycle at the falling edge.
module tb_multicycle_control_fsm;

  localparam int W = 17;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic       illegal_op, instr_retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

  multicycle_control_fsm #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .imm_src(imm_src), .illegal_op(illegal_op), .instr_retire(instr_retire)
  );

  // Clock
  always #5 clk = ~clk;

  // The output word is ordered:
  // pcw adr mw irw rs[2] sa[2] sb[2] aop[2] rw imm[2] ill ret
  logic [W-1:0] act;
  assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_op, reg_write, imm_src, illegal_op, instr_retire};

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
  endfunction

  function automatic logic [W-1:0] vec(input logic [6:0] o, input logic pcw,
      input logic adr, input logic mw, input logic irw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] aop,
      input logic rw, input logic ill, input logic ret);
    return {pcw, adr, mw, irw, rs, sa, sb, aop, rw, imm_of(o), ill, ret};
  endfunction

  // Driver: one cycle of stimulus plus that cycle's expected output word.
  task automatic cyc(input logic [6:0] o, input logic mr, input logic z,
                     input logic [W-1:0] e);
    @(posedge clk);
    #1;
    rst = 1'b0;
    op = o;
    mem_ready = mr;
    zero = z;
    exp_q.push_back(e);
  endtask

  // Hold reset. The enables read 0 and the selects take their fetch values.
  task automatic reset_cycles(input int n, input logic [6:0] o);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      op = o;
      mem_ready = 1'($urandom_range(0, 1));
      exp_q.push_back(vec(o, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0));
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference model. An instruction is a fetch with fs stalls, then a decode,
  // then the phases of its class. Memory phases take ms stalls. z is the zero
  // flag presented in the branch cycle. When abort is set, a store is cut off
  // by reset after its stall cycles.
  task automatic run_instr(input logic [6:0] o, input int fs, input int ms,
                           input logic z, input logic abort);
    for (int i = 0; i < fs; i++)
      cyc(o, 0, rb(), vec(o, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0));
    cyc(o, 1, rb(), vec(o, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0));
    cyc(o, rb(), rb(), vec(o, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, !is_legal(o), 0));
    if (o == LW || o == SW)
      cyc(o, rb(), rb(), vec(o, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0));
    if (o == LW) begin
      for (int i = 0; i <= ms; i++)
        cyc(o, i == ms, rb(), vec(o, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
      cyc(o, rb(), rb(), vec(o, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 1));
    end else if (o == SW) begin
      for (int i = 0; i < ms; i++)
        cyc(o, 0, rb(), vec(o, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
      if (abort) reset_cycles(2, o);
      else cyc(o, 1, rb(), vec(o, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1));
    end else if (o == RT || o == IT || o == JL) begin
      if (o == RT)
        cyc(o, rb(), rb(), vec(o, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0));
      else if (o == IT)
        cyc(o, rb(), rb(), vec(o, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0));
      else
        cyc(o, rb(), rb(), vec(o, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0));
      cyc(o, rb(), rb(), vec(o, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1));
    end else if (o == BQ) begin
      cyc(o, rb(), z, vec(o, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 1));
    end
  endtask

  // Monitor: compare the DUT outputs against the queued word every cycle.
  always begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL ctrl_out t=%0t op=%b actual=%b required=%b", $time, op, act, e);
      end
    end
  end

  function automatic logic [6:0] pick_op();
    logic [6:0] o;
    case ($urandom_range(0, 6))
      0: o = LW;
      1: o = SW;
      2: o = RT;
      3: o = IT;
      4: o = JL;
      5: o = BQ;
      default: begin
        o = 7'($urandom);
        while (is_legal(o)) o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  initial begin
    reset_cycles(2, 7'd0);
    // Directed sequence
    run_instr(RT, 0, 0, 0, 0);
    run_instr(LW, 0, 2, 0, 0);
    run_instr(SW, 0, 3, 0, 0);
    run_instr(BQ, 0, 0, 1, 0);
    run_instr(BQ, 0, 0, 0, 0);
    run_instr(JL, 0, 0, 0, 0);
    run_instr(IT, 1, 0, 0, 0);
    run_instr(7'b1111111, 0, 0, 0, 0);
    run_instr(SW, 0, 1, 0, 1);
    run_instr(RT, 2, 0, 0, 0);
    // Random sequence, with an occasional reset in the middle of a store
    for (int k = 0; k < 250; k++) begin
      logic [6:0] o;
      o = pick_op();
      run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), rb(),
                (o == SW) && ($urandom_range(0, 7) == 0));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Time limit on the whole run
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog actual=running required=finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
